sfx_buzzer: RTL and testbench

SFX_BUZZER -- requirements
Module: sfx_buzzer

---
 rtl/sfx_pkg.sv | 54 +++++
 rtl/tone_gen.sv | 45 ++++
 rtl/sfx_buzzer.sv | 179 +++++++++++++++++
 tb/tb_sfx_buzzer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// sfx_pkg: shared encodings and constants for the sound-effect buzzer.
// Holds game-mode codes, event/priority codes, note pitches and lengths,
// the inter-note gap, and the half-period helper used to build the note ROM.
package sfx_pkg;

    typedef enum logic [1:0] {
        GM_IDLE    = 2'b00,
        GM_PLAYING = 2'b01,
        GM_PAUSED  = 2'b10,
        GM_OVER    = 2'b11
    } gamemode_e;

    // Numeric order doubles as priority: a larger code preempts a smaller one.
    typedef enum logic [1:0] {
        EVT_NONE  = 2'd0,
        EVT_JUMP  = 2'd1,
        EVT_START = 2'd2,
        EVT_CRASH = 2'd3
    } event_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_e;

    localparam int HP_W    = 20;
    localparam int MS_W    = 10;
    localparam int PRESC_W = 17;

    localparam int F_JUMP = 1000;
    localparam int F_C5   = 523;
    localparam int F_G5   = 784;
    localparam int F_C4   = 262;

    localparam int D_JUMP_MS       = 50;
    localparam int D_START_MS      = 100;
    localparam int D_CRASH_MS      = 200;
    localparam int D_CRASH_LAST_MS = 400;

    localparam int GAP_MS = 20;

    typedef struct packed {
        logic [HP_W-1:0] half_period;
        logic [MS_W-1:0] dur_ms;
        logic            last;
    } note_t;

    // Tone counter reload: cycles per half period, truncated.
    function automatic logic [HP_W-1:0] half_period_of(input int clk_hz, input int freq_hz);
        return HP_W'(clk_hz / (2 * freq_hz));
    endfunction

endpackage

// File: rtl/tone_gen.sv
// tone_gen: half-period down-counter square-wave generator.
// While en is low the counter is held at the reload value and the wave at 0,
// so every note starts from a low output and a fresh count.
module tone_gen
    import sfx_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [HP_W-1:0] half_period,
    output logic            wave
);

    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            wave_q, wave_d;

    // Next count and wave: reload and toggle on terminal count.
    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (!en) begin
            cnt_d  = half_period;
            wave_d = 1'b0;
        end else if (cnt_q <= HP_W'(1)) begin
            cnt_d  = half_period;
            wave_d = ~wave_q;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter and wave registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/sfx_buzzer.sv
// sfx_buzzer: game sound-effect sequencer driving a passive buzzer.
// Optional feature macro: SFX_JUMP_EN (defined -> button presses while
// playing trigger the JUMP chirp; undefined -> buttons are ignored).
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | silent, waiting for an event
// ST_NOTE | playing note idx_q of sequence seq_q
// ST_GAP  | silent 20 ms spacer before the next note
module sfx_buzzer
    import sfx_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gamemode,
    input  logic [2:0] btn,
    output logic       buzzer,
    output logic       busy
);

    localparam logic [PRESC_W-1:0] MS_RELOAD = PRESC_W'(CLK_HZ / 1000 - 1);

    function automatic note_t mk_note(input int freq_hz, input int dur_ms, input logic last);
        note_t n;
        n.half_period = half_period_of(CLK_HZ, freq_hz);
        n.dur_ms      = MS_W'(dur_ms);
        n.last        = last;
        return n;
    endfunction

    function automatic note_t note_rom(input event_e seq, input logic [1:0] idx);
        note_t n;
        n      = '0;
        n.last = 1'b1;
        case ({seq, idx})
`ifdef SFX_JUMP_EN
            {EVT_JUMP, 2'd0}:  n = mk_note(F_JUMP, D_JUMP_MS, 1'b1);
`endif
            {EVT_START, 2'd0}: n = mk_note(F_C5, D_START_MS, 1'b0);
            {EVT_START, 2'd1}: n = mk_note(F_G5, D_START_MS, 1'b1);
            {EVT_CRASH, 2'd0}: n = mk_note(F_G5, D_CRASH_MS, 1'b0);
            {EVT_CRASH, 2'd1}: n = mk_note(F_C5, D_CRASH_MS, 1'b0);
            {EVT_CRASH, 2'd2}: n = mk_note(F_C4, D_CRASH_LAST_MS, 1'b1);
            default: ;
        endcase
        return n;
    endfunction

    seq_state_e         state_q, state_d;
    event_e             seq_q, seq_d, evt;
    logic [1:0]         idx_q, idx_d;
    logic [MS_W-1:0]    ms_q, ms_d;
    logic [PRESC_W-1:0] presc_q;
    logic [1:0]         gm_q;
    logic               prev_vld_q;
    logic               tick, crash_ev, start_ev, jump_ev, load, tone_en;
    note_t              note_first, note_next, note_cur, note_play;
    logic               unused_note_bits;

    // prev_vld_q keeps the reset values of the prev copies from looking like a transition.
    assign crash_ev = prev_vld_q && (gamemode == GM_OVER) && (gm_q != GM_OVER);
    assign start_ev = prev_vld_q && (gm_q == GM_IDLE) && (gamemode == GM_PLAYING);

`ifdef SFX_JUMP_EN
    logic [2:0] btn_q;

    // Previous button levels for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) btn_q <= 3'b000;
        else     btn_q <= btn;
    end

    assign jump_ev = prev_vld_q && (gamemode == GM_PLAYING) && |(btn & ~btn_q);
`else
    logic unused_btn;
    assign unused_btn = ^btn;
    assign jump_ev    = 1'b0;
`endif

    // Highest-priority event of this cycle.
    always_comb begin
        evt = EVT_NONE;
        if (crash_ev)      evt = EVT_CRASH;
        else if (start_ev) evt = EVT_START;
        else if (jump_ev)  evt = EVT_JUMP;
    end

    assign tick       = (presc_q == '0);
    assign note_first = note_rom(evt, 2'd0);
    assign note_next  = note_rom(seq_q, idx_q + 2'd1);
    assign note_cur   = note_rom(seq_q, idx_q);
    assign note_play  = note_rom(seq_d, idx_d);

    assign unused_note_bits = ^{note_first.half_period, note_first.last,
                                note_next.half_period, note_next.last,
                                note_cur.half_period, note_cur.dur_ms,
                                note_play.dur_ms, note_play.last};

    // Sequencer next state: pause abort, preemption, note/gap timing.
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        idx_d   = idx_q;
        ms_d    = ms_q;
        load    = 1'b0;
        if (gamemode == GM_PAUSED) begin
            state_d = ST_IDLE;
        end else if (evt != EVT_NONE && (state_q == ST_IDLE || evt > seq_q)) begin
            state_d = ST_NOTE;
            seq_d   = evt;
            idx_d   = 2'd0;
            ms_d    = note_first.dur_ms;
            load    = 1'b1;
        end else begin
            case (state_q)
                ST_NOTE: begin
                    if (tick) begin
                        if (ms_q <= MS_W'(1)) begin
                            state_d = note_cur.last ? ST_IDLE : ST_GAP;
                            ms_d    = MS_W'(GAP_MS);
                        end else begin
                            ms_d = ms_q - 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (ms_q <= MS_W'(1)) begin
                            state_d = ST_NOTE;
                            idx_d   = idx_q + 2'd1;
                            ms_d    = note_next.dur_ms;
                            load    = 1'b1;
                        end else begin
                            ms_d = ms_q - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer, prev-copy and ms prescaler registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            seq_q      <= EVT_NONE;
            idx_q      <= 2'd0;
            ms_q       <= '0;
            presc_q    <= '0;
            gm_q       <= 2'b00;
            prev_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            idx_q      <= idx_d;
            ms_q       <= ms_d;
            presc_q    <= tick ? MS_RELOAD : presc_q - 1'b1;
            gm_q       <= gamemode;
            prev_vld_q <= 1'b1;
        end
    end

    // Tone is held off on the load cycle so each note restarts from a low wave.
    assign tone_en = (state_d == ST_NOTE) && !load;

    tone_gen u_tone (
        .clk         (clk),
        .rst         (rst),
        .en          (tone_en),
        .half_period (note_play.half_period),
        .wave        (buzzer)
    );

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sfx_buzzer.sv
// tb_sfx_buzzer: randomized self-checking bench for sfx_buzzer.
// A reduced CLK_HZ keeps the longest sequence within a short run.
module tb_sfx_buzzer;

    localparam int CLK_HZ   = 20_000;
    localparam int CYC_MS   = CLK_HZ / 1000;
    localparam int GAP_CYC  = 20 * CYC_MS;
    localparam int SPLIT    = 10 * CYC_MS;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gamemode;
    logic [2:0] btn;
    logic       buzzer;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        int         kind;   // 0: gamemode, 1: btn
        logic [2:0] val;
    } act_t;

    act_t acts[$];
    int   tog_t[$];
    logic tog_v[$];
    int   busy_len;
    int   exp_f[$];
    int   exp_d[$];

    sfx_buzzer #(.CLK_HZ(CLK_HZ)) dut (
        .clk      (clk),
        .rst      (rst),
        .gamemode (gamemode),
        .btn      (btn),
        .buzzer   (buzzer),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int hp_of(input int f);
        return CLK_HZ / (2 * f);
    endfunction

    // Reference sequences: 0 jump, 1 start, 2 crash.
    task automatic set_seq(input int which);
        exp_f.delete();
        exp_d.delete();
        case (which)
            0: begin exp_f.push_back(1000); exp_d.push_back(50); end
            1: begin
                exp_f.push_back(523); exp_d.push_back(100);
                exp_f.push_back(784); exp_d.push_back(100);
            end
            default: begin
                exp_f.push_back(784); exp_d.push_back(200);
                exp_f.push_back(523); exp_d.push_back(200);
                exp_f.push_back(262); exp_d.push_back(400);
            end
        endcase
    endtask

    function automatic int exp_len();
        int s = 0;
        foreach (exp_d[i]) s += exp_d[i] * CYC_MS;
        return s + (exp_d.size() - 1) * GAP_CYC;
    endfunction

    // Record buzzer transitions until busy falls, applying scheduled actions.
    task automatic capture(input string name);
        logic prev_bz;
        int   t;
        int   max_cyc;
        max_cyc = exp_len() + 20 * CYC_MS;
        tog_t.delete();
        tog_v.delete();
        t = 0;
        prev_bz = buzzer;
        while (busy === 1'b1 && t < max_cyc) begin
            foreach (acts[i]) begin
                if (acts[i].cyc == t) begin
                    if (acts[i].kind == 0) gamemode = acts[i].val[1:0];
                    else                   btn = acts[i].val;
                end
            end
            step();
            t++;
            if (buzzer !== prev_bz) begin
                tog_t.push_back(t);
                tog_v.push_back(buzzer);
            end
            prev_bz = buzzer;
        end
        acts.delete();
        busy_len = t;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s timeout: busy=%b after %0d cycles, required 0", name, busy, t);
        end
    endtask

    // Compare captured waveform against the reference note list.
    task automatic check_seq(input string name);
        int n;
        int g;
        int cnt[$];
        int bad[$];
        int iv;
        int exp_hp;
        logic grp_end;
        n = exp_f.size();
        g = -1;
        for (int i = 0; i < tog_t.size(); i++) begin
            if (i == 0 || tog_t[i] - tog_t[i-1] > SPLIT) begin
                g++;
                cnt.push_back(0);
                bad.push_back(0);
            end else if (g < n) begin
                iv = tog_t[i] - tog_t[i-1];
                exp_hp = hp_of(exp_f[g]);
                grp_end = (i == tog_t.size() - 1) || (tog_t[i+1] - tog_t[i] > SPLIT);
                // A note cut short at its end may drop the wave to 0 early.
                if (iv != exp_hp && !(grp_end && tog_v[i] == 1'b0 && iv < exp_hp))
                    bad[g] = bad[g] + 1;
            end
            cnt[g] = cnt[g] + 1;
        end
        checks++;
        if (g + 1 != n) begin
            failures++;
            $display("FAIL %s notes: got %0d tone bursts, required %0d", name, g + 1, n);
        end
        checks++;
        if (tog_t.size() == 0 || tog_t[0] != hp_of(exp_f[0])) begin
            failures++;
            $display("FAIL %s first_toggle: got cycle %0d, required %0d",
                     name, (tog_t.size() == 0) ? -1 : tog_t[0], hp_of(exp_f[0]));
        end
        for (int k = 0; k < n && k <= g; k++) begin
            int hpk, lo, hi;
            hpk = hp_of(exp_f[k]);
            lo  = (exp_d[k] - 1) * CYC_MS / hpk - 1;
            hi  = (exp_d[k] + 1) * CYC_MS / hpk + 1;
            checks++;
            if (bad[k] != 0) begin
                failures++;
                $display("FAIL %s note%0d period: %0d intervals differ from required %0d cycles",
                         name, k, bad[k], hpk);
            end
            checks++;
            if (cnt[k] < lo || cnt[k] > hi) begin
                failures++;
                $display("FAIL %s note%0d toggles: got %0d, required %0d..%0d", name, k, cnt[k], lo, hi);
            end
        end
        checks++;
        if (busy_len < exp_len() - (2 * n - 1) * CYC_MS || busy_len > exp_len() + (2 * n - 1) * CYC_MS) begin
            failures++;
            $display("FAIL %s busy_len: got %0d, required %0d +/- %0d",
                     name, busy_len, exp_len(), (2 * n - 1) * CYC_MS);
        end
        checks++;
        if (buzzer !== 1'b0) begin
            failures++;
            $display("FAIL %s end_buzzer: got %b, required 0", name, buzzer);
        end
    endtask

    task automatic expect_start(input string name);
        step();
        checks++;
        if (busy !== 1'b1 || buzzer !== 1'b0) begin
            failures++;
            $display("FAIL %s start: busy=%b buzzer=%b, required busy=1 buzzer=0", name, busy, buzzer);
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            step();
            if (busy !== 1'b0 || buzzer !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL %s quiet: %0d cycles with busy/buzzer high, required 0", name, seen);
        end
    endtask

    task automatic begin_start();
        gamemode = 2'b00;
        repeat ($urandom_range(20, 2)) step();
        gamemode = 2'b01;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gamemode = 2'b00;
        btn = 3'b000;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || buzzer !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%b buzzer=%b, required 0 0", busy, buzzer);
        end
        gamemode = 2'b01;
        step();
        rst = 1'b0;
        expect_quiet("reset_release_playing", 200);
    endtask

    task automatic test_start();
        begin_start();
        expect_start("start");
        set_seq(1);
        capture("start");
        check_seq("start");
    endtask

`ifdef SFX_JUMP_EN
    task automatic test_jump();
        gamemode = 2'b01;
        repeat ($urandom_range(30, 3)) step();
        btn = 3'($urandom_range(7, 1));
        expect_start("jump");
        acts.push_back('{cyc: 5,  kind: 1, val: 3'b000});
        acts.push_back('{cyc: 10, kind: 1, val: 3'($urandom_range(7, 1))});
        set_seq(0);
        capture("jump");
        check_seq("jump");
        btn = 3'b000;
        step();
    endtask
`else
    task automatic test_btn_ignored();
        int seen;
        gamemode = 2'b01;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            btn = 3'($urandom_range(7, 0));
            repeat (3) begin
                step();
                if (busy !== 1'b0) seen++;
            end
            btn = 3'b000;
            step();
            if (busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL btn_ignored: busy high %0d cycles, required 0", seen);
        end
    endtask
`endif

    task automatic test_equal_drop();
        int c;
        begin_start();
        expect_start("start_drop");
        c = $urandom_range(3000, 100);
        acts.push_back('{cyc: c,     kind: 0, val: 3'b000});
        acts.push_back('{cyc: c + 3, kind: 0, val: 3'b001});
        set_seq(1);
        capture("start_drop");
        check_seq("start_drop");
    endtask

    task automatic test_preempt();
        int c;
        begin_start();
        expect_start("preempt_start");
        repeat ($urandom_range(1500, 50)) step();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL preempt_mid: busy=%b, required 1", busy);
        end
        gamemode = 2'b11;
        expect_start("crash");
        c = $urandom_range(5000, 100);
        acts.push_back('{cyc: c,      kind: 1, val: 3'($urandom_range(7, 1))});
        acts.push_back('{cyc: c + 20, kind: 1, val: 3'b000});
        set_seq(2);
        capture("crash");
        check_seq("crash");
    endtask

    task automatic test_pause();
        int seen;
        gamemode = 2'b01;
        expect_quiet("over_to_playing", 30);
        gamemode = 2'b11;
        expect_start("pause_crash");
        repeat ($urandom_range(5000, 10)) step();
        gamemode = 2'b10;
        step();
        checks++;
        if (busy !== 1'b0 || buzzer !== 1'b0) begin
            failures++;
            $display("FAIL pause_abort: busy=%b buzzer=%b, required 0 0", busy, buzzer);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            btn = 3'($urandom_range(7, 1));
            repeat (2) begin step(); if (busy !== 1'b0) seen++; end
            btn = 3'b000;
            repeat (2) begin step(); if (busy !== 1'b0) seen++; end
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL pause_btn: busy high %0d cycles, required 0", seen);
        end
        gamemode = 2'b01;
        expect_quiet("paused_to_playing", 50);
    endtask

    task automatic test_reset_mid_note();
        begin_start();
        expect_start("reset_mid");
        repeat ($urandom_range(1500, 10)) step();
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || buzzer !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_abort: busy=%b buzzer=%b, required 0 0", busy, buzzer);
        end
        repeat (2) step();
        rst = 1'b0;
        expect_quiet("reset_mid_release", 300);
    endtask

    initial begin
        test_reset();
        test_start();
`ifdef SFX_JUMP_EN
        test_jump();
`else
        test_btn_ignored();
`endif
        test_equal_drop();
        test_preempt();
        test_pause();
        test_reset_mid_note();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
